wb_shared_bus: RTL
==================

# wb_shared_bus

Parametrised Wishbone shared-bus interconnect joining NM bus masters to NS slaves. Round-robin arbitration grants one master at a time; the granted master's address then selects a slave through high-bit decode. Unmapped addresses and stalled slaves return an error. It sits between the CPU/DMA masters and the peripheral slaves, in place of the single-master address-decode crossbar.

## Interface
- NM, 2: number of masters (1..8).
- NS, 2: number of slaves (1..2^(AW-MSK)).
- MSK, 24: address bits [AW-1:MSK] select the slave.
- AW, 32: address width.
- DW, 32: data width.
- SW, DW>>3: byte-select width.
- TO_CYC, 255: timeout in cycles; legal range 1..65535.

- clk  in  1  Clock.
- rst_n  in  1  Reset, asynchronous, active-low.
- s_wb_adr  in  AW*NM  Master addresses, master k at [AW*(k+1)-1:AW*k]. Same packing rule for every bus below.
- s_wb_sel  in  SW*NM  Master byte selects.
- s_wb_we  in  NM  Master write enables.
- s_wb_dat_i  in  DW*NM  Master write data.
- s_wb_dat_o  out  DW*NM  Read data to the masters.
- s_wb_cyc  in  NM  Master cycle.
- s_wb_stb  in  NM  Master strobe.
- s_wb_ack  out  NM  Ack to the masters.
- s_wb_err  out  NM  Error to the masters.
- m_wb_adr  out  AW*NS  Slave address.
- m_wb_sel  out  SW*NS  Slave byte selects.
- m_wb_we  out  NS  Slave write enable.
- m_wb_dat_o  out  DW*NS  Slave write data.
- m_wb_dat_i  in  DW*NS  Slave read data.
- m_wb_cyc  out  NS  Slave cycle.
- m_wb_stb  out  NS  Slave strobe.
- m_wb_ack  in  NS  Slave ack.
- m_wb_err  in  NS  Slave error.
- grant  out  NM  One-hot grant, for debug.

## Operation
- Arbiter states:
  - IDLE: no grant.
  - BUSY: exactly one master granted.
- IDLE → BUSY:
  - Taken when any s_wb_cyc is high.
  - The winner is the first requesting master at or after rr_ptr, searching upward with wrap.
  - The grant register loads the winner.
- BUSY → IDLE:
  - Taken when the granted master's cyc is low.
  - rr_ptr ← granted index + 1, mod NM.
  - Grant clears.
- Masters are never preempted: the grant holds for the whole cyc, including multi-beat bursts.
- In BUSY, sel = adr_g[AW-1:MSK] of the granted master g.
  - If sel < NS, slave sel receives the cycle.
  - adr/sel/dat_o are broadcast to all slaves. cyc, stb and we are qualified by the one-hot slave enable.
  - s_wb_ack[g] = m_wb_ack[sel] and s_wb_err[g] = m_wb_err[sel], combinational.
- Unmapped address (sel ≥ NS) with stb high:
  - No slave is strobed.
  - s_wb_err[g] = 1 in the same cycle.
- s_wb_dat_o = read data of the selected slave, broadcast to all masters. Only the granted master receives ack/err.
- Non-granted masters see ack = err = 0 and wait.
- Reset:
  - State IDLE, grant 0, rr_ptr 0, timeout counter 0.
  - All m_wb_cyc/stb/we = 0; all s_wb_ack/err = 0.
  - Reset asserted mid-transfer drops the slave cyc immediately (asynchronous).

## Timing
- Arbitration latency:
  - 1 cycle from a cyc rise in IDLE to the grant.
  - The slave stb is first visible in the cycle after the master raises cyc+stb.
- Bus-release bubble: 1 IDLE cycle between consecutive owners.
- Data path (adr/dat/ack/err): combinational through the interconnect, zero added latency once granted.
- Simultaneous requests: the round-robin order decides; the same master is never granted twice in a row while another master requests.
- A master that drops cyc in the same cycle the slave acks completes normally.

## Configuration
- WB_SHARED_BUS_TIMEOUT_EN defined:
  - A 16-bit counter increments each BUSY cycle with granted stb high and neither ack nor err.
  - At count == TO_CYC it pulses s_wb_err[g] for 1 cycle and clears; slave stb stays as driven by the master.
  - The counter clears on ack, err, or grant change.
- WB_SHARED_BUS_TIMEOUT_EN undefined:
  - No counter logic.
  - A stalled slave hangs the bus indefinitely.

## Structure
- Shared package holds:
  - The state encoding (IDLE=0, BUSY=1).
  - The round-robin helper function: next requester given a request vector and pointer.
- Sub-module wb_rr_arbiter, parametrised on NM, contains rr_ptr, the grant register and the IDLE/BUSY state.
- The top holds the decode, the muxing and the optional timeout counter.

## Test plan
- Single master, NM=2, NS=2: master 0 reads 0x0100_0004, slave 1 acks with 0xDEADBEEF → slave 1 sees stb one cycle after the request; master 0 gets ack and 0xDEADBEEF; slave 0 cyc stays 0.
- Contention: both masters raise cyc in the same cycle out of reset → master 0 granted first; after it releases, master 1 is granted following a 1-cycle bubble; next simultaneous request goes to master 0 again.
- Unmapped address: master 1 accesses 0x0500_0000 with NS=2 → err in the same cycle as stb; no m_wb_stb asserted.
- Burst lock: master 0 holds cyc for 4 acked beats while master 1 requests → master 1 waits; grant changes only after master 0 drops cyc.
- Timeout (macro on, TO_CYC=8): slave never acks → one err pulse after 8 stalled cycles; counter restarts from 0.
- Reset mid-transfer: deassert rst_n during BUSY → all m_wb_cyc/stb and grant go 0 immediately; the first request after reset is arbitrated from master 0.

Source files
------------

// File: rtl/wb_shared_bus_pkg.sv
// Shared definitions for the Wishbone shared-bus interconnect: arbiter state
// encoding and the round-robin requester search.
package wb_shared_bus_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam int MAX_NM = 8;

    // First requester at or after ptr, searching upward and wrapping at nm.
    function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int nm);
        logic [2:0] pick;
        logic [2:0] idx;
        logic       found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < MAX_NM; i++) begin
            idx = 3'((int'(ptr) + i) % nm);
            if (!found && (i < nm) && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Round-robin bus arbiter: holds the IDLE/BUSY state, the one-hot grant and
// the rotating priority pointer. A grant lasts until the owner drops cyc.
module wb_rr_arbiter
    import wb_shared_bus_pkg::*;
#(
    parameter int NM = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [NM-1:0] req,
    output logic [NM-1:0] grant,
    output logic          busy
);

    logic [0:0] state;
    logic [2:0] rr_ptr;
    logic [2:0] gidx;
    logic [2:0] winner;
    logic [7:0] req_ext;

    always_comb begin
        req_ext         = '0;
        req_ext[NM-1:0] = req;
    end

    assign winner = rr_pick(req_ext, rr_ptr, NM);
    assign busy   = (state == ST_BUSY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            grant  <= '0;
            gidx   <= '0;
            rr_ptr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        state <= ST_BUSY;
                        grant <= NM'(1'b1) << winner;
                        gidx  <= winner;
                    end
                end
                default: begin
                    // Release only when the owner ends its cycle; no preemption.
                    if (!req_ext[gidx]) begin
                        state  <= ST_IDLE;
                        grant  <= '0;
                        rr_ptr <= (gidx == 3'(NM - 1)) ? 3'd0 : gidx + 3'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/wb_shared_bus.sv
// Wishbone shared bus: NM masters arbitrated onto NS slaves by high-bit
// address decode. Optional stall timeout under WB_SHARED_BUS_TIMEOUT_EN.
module wb_shared_bus
    import wb_shared_bus_pkg::*;
#(
    parameter int NM     = 2,
    parameter int NS     = 2,
    parameter int MSK    = 24,
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int SW     = DW >> 3,
    parameter int TO_CYC = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW*NM-1:0] s_wb_adr,
    input  logic [SW*NM-1:0] s_wb_sel,
    input  logic [NM-1:0]    s_wb_we,
    input  logic [DW*NM-1:0] s_wb_dat_i,
    output logic [DW*NM-1:0] s_wb_dat_o,
    input  logic [NM-1:0]    s_wb_cyc,
    input  logic [NM-1:0]    s_wb_stb,
    output logic [NM-1:0]    s_wb_ack,
    output logic [NM-1:0]    s_wb_err,
    output logic [AW*NS-1:0] m_wb_adr,
    output logic [SW*NS-1:0] m_wb_sel,
    output logic [NS-1:0]    m_wb_we,
    output logic [DW*NS-1:0] m_wb_dat_o,
    input  logic [DW*NS-1:0] m_wb_dat_i,
    output logic [NS-1:0]    m_wb_cyc,
    output logic [NS-1:0]    m_wb_stb,
    input  logic [NS-1:0]    m_wb_ack,
    input  logic [NS-1:0]    m_wb_err,
    output logic [NM-1:0]    grant
);

    localparam int SLW = AW - MSK;

    logic          busy;
    logic [AW-1:0] adr_g;
    logic [SW-1:0] sel_g;
    logic [DW-1:0] dat_g;
    logic          we_g;
    logic          cyc_g;
    logic          stb_g;
    logic [SLW-1:0] slv;
    logic          mapped;
    logic [NS-1:0] en;
    logic [DW-1:0] dat_sel;
    logic          ack_sel;
    logic          err_sel;
    logic          ack_g;
    logic          err_g;
    logic          decode_err;
    logic          to_pulse;

    wb_rr_arbiter #(.NM(NM)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (s_wb_cyc),
        .grant (grant),
        .busy  (busy)
    );

    // Grant is one-hot (or zero in IDLE), so an OR-style mux picks the owner.
    always_comb begin
        adr_g = '0;
        sel_g = '0;
        dat_g = '0;
        we_g  = 1'b0;
        cyc_g = 1'b0;
        stb_g = 1'b0;
        for (int k = 0; k < NM; k++) begin
            if (grant[k]) begin
                adr_g = s_wb_adr[k*AW +: AW];
                sel_g = s_wb_sel[k*SW +: SW];
                dat_g = s_wb_dat_i[k*DW +: DW];
                we_g  = s_wb_we[k];
                cyc_g = busy & s_wb_cyc[k];
                stb_g = busy & s_wb_stb[k];
            end
        end
    end

    assign slv    = adr_g[AW-1:MSK];
    assign mapped = ({1'b0, slv} < (SLW + 1)'(NS));

    always_comb begin
        en      = '0;
        dat_sel = '0;
        ack_sel = 1'b0;
        err_sel = 1'b0;
        for (int j = 0; j < NS; j++) begin
            if (mapped && (slv == SLW'(j))) begin
                en[j]   = cyc_g;
                dat_sel = m_wb_dat_i[j*DW +: DW];
                ack_sel = m_wb_ack[j];
                err_sel = m_wb_err[j];
            end
        end
    end

    assign m_wb_adr   = {NS{adr_g}};
    assign m_wb_sel   = {NS{sel_g}};
    assign m_wb_dat_o = {NS{dat_g}};
    assign m_wb_cyc   = en;
    assign m_wb_stb   = en & {NS{stb_g}};
    assign m_wb_we    = en & {NS{we_g}};

    // Unmapped strobes are answered here so the master never waits on nobody.
    assign decode_err = cyc_g & stb_g & ~mapped;
    assign ack_g      = cyc_g & ack_sel;
    assign err_g      = cyc_g & (err_sel | decode_err | to_pulse);

    assign s_wb_ack   = grant & {NM{ack_g}};
    assign s_wb_err   = grant & {NM{err_g}};
    assign s_wb_dat_o = {NM{dat_sel}};

`ifdef WB_SHARED_BUS_TIMEOUT_EN
    logic [15:0] to_cnt;

    assign to_pulse = busy & (to_cnt == 16'(TO_CYC));

    // Counts strobed cycles without a response; any response or owner change restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (!busy || ack_g || err_g) begin
            to_cnt <= '0;
        end else if (stb_g) begin
            to_cnt <= to_cnt + 16'd1;
        end
    end
`else
    assign to_pulse = 1'b0;
`endif

endmodule
